fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 34 +++
 rtl/fetch_unit.sv | 76 +++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: program-memory port, redirect controls and the
// instruction-register handshake toward the decode stage.
interface fetch_unit_if #(
  parameter int Psize = 5,
  parameter int Isize = 16
);
  // program memory side
  logic [Psize-1:0] address;
  logic [Isize-1:0] I;

  // fetch control
  logic             halt;
  logic             branch_en;
  logic             branch_rel;
  logic [Psize-1:0] branch_val;

  // instruction register handshake toward decode
  logic [Isize-1:0] ir;
  logic [Psize-1:0] ir_pc;
  logic             ir_valid;
  logic             ir_ready;

  // the fetch unit itself
  modport master (
    output address, ir, ir_pc, ir_valid,
    input  I, halt, branch_en, branch_rel, branch_val, ir_ready
  );

  // memory / decode environment around the fetch unit
  modport slave (
    input  address, ir, ir_pc, ir_valid,
    output I, halt, branch_en, branch_rel, branch_val, ir_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-stage instruction fetch: a PC drives program memory directly and
// the returned word is captured into a one-entry instruction register with a
// valid/ready handshake. Branches redirect the PC and flush the register,
// costing one bubble. Every output comes straight from a register.
module fetch_unit #(
  parameter int Psize = 5,
  parameter int Isize = 16
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  localparam logic [Psize-1:0] PcStep = Psize'(1);

  logic [Psize-1:0] pc_reg, pc_next;
  logic [Isize-1:0] ir_reg, ir_next;
  logic [Psize-1:0] ir_pc_reg, ir_pc_next;
  logic             ir_valid_reg, ir_valid_next;

  logic             transfer;
  logic             advance;
  logic [Psize-1:0] target;

  // Downstream consumes the held instruction on this edge.
  assign transfer = ir_valid_reg && bus.ir_ready;

  // A new fetch lands when the register is free (or being drained) and no
  // redirect is pending; a branch always wins over a fetch.
  assign advance = !bus.halt && (!ir_valid_reg || bus.ir_ready) && !bus.branch_en;

  // Relative targets are taken from the address of the instruction in ir;
  // the truncating add gives two's-complement wrap modulo 2^Psize for free.
  assign target = bus.branch_rel ? (ir_pc_reg + bus.branch_val) : bus.branch_val;

  // Next-state selection: branch flush, then fetch, then drain-only.
  always_comb begin
    pc_next       = pc_reg;
    ir_next       = ir_reg;
    ir_pc_next    = ir_pc_reg;
    ir_valid_next = ir_valid_reg;
    if (bus.branch_en) begin
      // ir/ir_pc are kept so a later relative branch still has a base.
      pc_next       = target;
      ir_valid_next = 1'b0;
    end else if (advance) begin
      ir_next       = bus.I;
      ir_pc_next    = pc_reg;
      ir_valid_next = 1'b1;
      pc_next       = pc_reg + PcStep;
    end else if (transfer) begin
      ir_valid_next = 1'b0;
    end
  end

  // State registers; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg       <= '0;
      ir_reg       <= '0;
      ir_pc_reg    <= '0;
      ir_valid_reg <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      ir_reg       <= ir_next;
      ir_pc_reg    <= ir_pc_next;
      ir_valid_reg <= ir_valid_next;
    end
  end

  assign bus.address  = pc_reg;
  assign bus.ir       = ir_reg;
  assign bus.ir_pc    = ir_pc_reg;
  assign bus.ir_valid = ir_valid_reg;

endmodule
